m68k_error_reporter: RTL and testbench

//  Downstream of the freerun address checker: queues address-mismatch events and formats each one as ASCII text.

---
 rtl/m68k_error_reporter.sv | 168 ++++++++++++++++
 tb/tb_m68k_error_reporter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m68k_error_reporter.sv
// Queues address-mismatch events and streams each as "E AAAAAA XXXXXX\r\n" to the AVR UART.
// Define M68K_ERR_DROP_REPORT_EN to append a "D HH\r\n" drop report once the queue drains.
module m68k_error_reporter #(
    parameter int EVT_DEPTH = 4,
    parameter int EVT_AW    = 2
) (
    input  logic            clk_sys,
    input  logic            rst,
    input  logic            evt_valid,
    input  logic [23:0]     evt_actual,
    input  logic [23:0]     evt_expected,
    input  logic            tx_busy,
    output logic [7:0]      tx_data,
    output logic            new_tx_data,
    output logic [7:0]      drop_cnt,
    output logic [EVT_AW:0] fifo_level,
    output logic            busy
);

`ifdef M68K_ERR_DROP_REPORT_EN
    typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, DROP} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;
`endif

    localparam logic [EVT_AW:0] FULL_LVL = (EVT_AW + 1)'(EVT_DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [47:0]       mem [EVT_DEPTH];
    logic [EVT_AW-1:0] wr_ptr;
    logic [EVT_AW-1:0] rd_ptr;
    logic [47:0]       msg;
    logic [4:0]        idx;
    logic [4:0]        last;
    logic              is_drop;
    logic              full;
    logic              push;
    logic              pop;
    logic              drop_hit;
    logic              strobe;
    logic [7:0]        cur_byte;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    assign full     = (fifo_level == FULL_LVL);
    assign push     = evt_valid && !full;
    assign drop_hit = evt_valid && full;
    assign pop      = (state == LOAD);
    assign last     = is_drop ? 5'd5 : 5'd16;
    assign busy     = (fifo_level != '0) || (state != IDLE);

    always_ff @(posedge clk_sys) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (fifo_level != '0) state_nxt = LOAD;
            LOAD: state_nxt = SEND;
            SEND: if (!tx_busy) state_nxt = GAP;
            GAP: begin
                if (idx != last)
                    state_nxt = SEND;
`ifdef M68K_ERR_DROP_REPORT_EN
                else if (!is_drop && fifo_level == '0 && drop_cnt != 8'h00)
                    state_nxt = DROP;
`endif
                else
                    state_nxt = IDLE;
            end
`ifdef M68K_ERR_DROP_REPORT_EN
            DROP: state_nxt = SEND;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Byte map; nibbles are picked MSB first by shifting the address field.
    always_comb begin
        strobe   = (state == SEND) && !tx_busy;
        cur_byte = 8'h0A;
        if (is_drop) begin
            unique case (idx)
                5'd0:    cur_byte = 8'h44;
                5'd1:    cur_byte = 8'h20;
                5'd2:    cur_byte = hex_char(msg[7:4]);
                5'd3:    cur_byte = hex_char(msg[3:0]);
                5'd4:    cur_byte = 8'h0D;
                default: cur_byte = 8'h0A;
            endcase
        end else begin
            unique case (1'b1)
                (idx == 5'd0):
                    cur_byte = 8'h45;
                (idx == 5'd1 || idx == 5'd8):
                    cur_byte = 8'h20;
                (idx >= 5'd2 && idx <= 5'd7):
                    cur_byte = hex_char(4'(msg[47:24] >> {5'd7 - idx, 2'b00}));
                (idx >= 5'd9 && idx <= 5'd14):
                    cur_byte = hex_char(4'(msg[23:0] >> {5'd14 - idx, 2'b00}));
                (idx == 5'd15):
                    cur_byte = 8'h0D;
                default:
                    cur_byte = 8'h0A;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr] <= {evt_actual, evt_expected};
    end

`ifndef M68K_ERR_DROP_REPORT_EN
    assign is_drop = 1'b0;
`endif

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            drop_cnt    <= 8'h00;
            tx_data     <= 8'h00;
            new_tx_data <= 1'b0;
            msg         <= '0;
            idx         <= '0;
`ifdef M68K_ERR_DROP_REPORT_EN
            is_drop     <= 1'b0;
`endif
        end else begin
            new_tx_data <= strobe;
            if (strobe) tx_data <= cur_byte;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                msg    <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
                idx    <= '0;
`ifdef M68K_ERR_DROP_REPORT_EN
                is_drop <= 1'b0;
`endif
            end
            if (push && !pop)
                fifo_level <= fifo_level + 1'b1;
            else if (pop && !push)
                fifo_level <= fifo_level - 1'b1;
            if (state == GAP && idx != last) idx <= idx + 1'b1;
`ifdef M68K_ERR_DROP_REPORT_EN
            // Snapshot the count for the report; drops seen now restart the live count.
            if (state == GAP && state_nxt == DROP) begin
                msg      <= {40'h0, drop_cnt};
                is_drop  <= 1'b1;
                idx      <= '0;
                drop_cnt <= drop_hit ? 8'd1 : 8'd0;
            end else if (drop_hit && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
`else
            if (drop_hit && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_m68k_error_reporter.sv
// Self-checking bench for m68k_error_reporter: byte streams checked against a text model.
// Honours M68K_ERR_DROP_REPORT_EN to expect or forbid the drop report line.
module tb_m68k_error_reporter;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        evt_valid = 1'b0;
    logic [23:0] evt_actual = '0;
    logic [23:0] evt_expected = '0;
    logic        tx_busy = 1'b0;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic [7:0]  drop_cnt;
    logic [2:0]  fifo_level;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_strobe = -100;
    logic [7:0] got[$];
    logic [7:0] exp[$];

    m68k_error_reporter #(.EVT_DEPTH(4), .EVT_AW(2)) dut (
        .clk_sys(clk_sys), .rst(rst), .evt_valid(evt_valid),
        .evt_actual(evt_actual), .evt_expected(evt_expected),
        .tx_busy(tx_busy), .tx_data(tx_data), .new_tx_data(new_tx_data),
        .drop_cnt(drop_cnt), .fifo_level(fifo_level), .busy(busy)
    );

    always #10 clk_sys = ~clk_sys;

    // Record every strobed byte shortly after the edge and police strobe spacing.
    always @(posedge clk_sys) begin
        #2;
        cyc++;
        if (new_tx_data) begin
            checks++;
            if (cyc - last_strobe < 2) begin
                errors++;
                $display("FAIL strobe_spacing gap %0d cycles, need >= 2", cyc - last_strobe);
            end
            last_strobe = cyc;
            got.push_back(tx_data);
        end
    end

    function automatic logic [7:0] hexc(input int n);
        if (n < 10) return 8'(48 + n);
        return 8'(65 + n - 10);
    endfunction

    function automatic void add_msg(input logic [23:0] a, input logic [23:0] e);
        exp.push_back(8'h45);
        exp.push_back(8'h20);
        for (int i = 20; i >= 0; i -= 4) exp.push_back(hexc(int'((a >> i) & 24'hF)));
        exp.push_back(8'h20);
        for (int i = 20; i >= 0; i -= 4) exp.push_back(hexc(int'((e >> i) & 24'hF)));
        exp.push_back(8'h0D);
        exp.push_back(8'h0A);
    endfunction

    function automatic void add_drop(input int n);
        exp.push_back(8'h44);
        exp.push_back(8'h20);
        exp.push_back(hexc(n / 16));
        exp.push_back(hexc(n % 16));
        exp.push_back(8'h0D);
        exp.push_back(8'h0A);
    endfunction

    function automatic int first_diff();
        int n;
        n = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int i = 0; i < n; i++) if (got[i] !== exp[i]) return i;
        if (got.size() != exp.size()) return n;
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        evt_valid = 1'b0;
        tx_busy = 1'b0;
        repeat (3) @(negedge clk_sys);
        rst = 1'b0;
        got.delete();
        exp.delete();
        last_strobe = -100;
    endtask

    task automatic push_evt(input logic [23:0] a, input logic [23:0] e);
        evt_actual = a;
        evt_expected = e;
        evt_valid = 1'b1;
        @(negedge clk_sys);
        evt_valid = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget, input string name);
        int t = 0;
        while (got.size() < n && t < budget) begin
            @(negedge clk_sys);
            t++;
        end
        if (got.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got %0d strobes want %0d", name, got.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int t = 0;
        while (busy && t < budget) begin
            @(negedge clk_sys);
            t++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_timeout busy still 1 want 0", name);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
        if (new_tx_data !== 1'b0) begin errors++; $display("FAIL rst_strobe got %b want 0", new_tx_data); end
        if (drop_cnt !== 8'h00) begin errors++; $display("FAIL rst_drop got %h want 00", drop_cnt); end
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d want 0", fifo_level); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    endtask

    task automatic test_single();
        int d;
        do_reset();
        push_evt(24'h00ABCD, 24'h000008);
        add_msg(24'h00ABCD, 24'h000008);
        wait_strobes(17, 200, "single");
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_last got %b want 1", busy); end
        @(negedge clk_sys);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall got %b want 0", busy); end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL single_stream byte %0d got %0d bytes want %0d", d, got.size(), exp.size());
        end
        checks++;
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL single_level got %0d want 0", fifo_level); end
    endtask

    task automatic test_stall();
        int d;
        logic [23:0] a, e;
        do_reset();
        a = 24'($urandom);
        e = 24'($urandom);
        push_evt(a, e);
        add_msg(a, e);
        wait_strobes(3, 100, "stall");
        tx_busy = 1'b1;
        repeat (100) @(negedge clk_sys);
        checks++;
        if (got.size() != 3) begin errors++; $display("FAIL stall_hold got %0d strobes want 3", got.size()); end
        tx_busy = 1'b0;
        wait_strobes(4, 50, "stall_release");
        checks++;
        if (got.size() >= 4 && got[3] !== exp[3]) begin
            errors++;
            $display("FAIL stall_byte4 got %h want %h", got[3], exp[3]);
        end
        wait_idle(200, "stall");
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL stall_stream byte %0d got %0d bytes want %0d", d, got.size(), exp.size());
        end
    endtask

    task automatic test_back_to_back();
        int d;
        logic [23:0] a, e;
        do_reset();
        a = 24'($urandom);
        e = 24'($urandom);
        push_evt(a, e);
        add_msg(a, e);
        wait_strobes(1, 100, "b2b");
        tx_busy = 1'b1;
        repeat (2) @(negedge clk_sys);
        for (int i = 0; i < 6; i++) begin
            a = 24'($urandom);
            e = 24'($urandom);
            if (i < 4) add_msg(a, e);
            evt_actual = a;
            evt_expected = e;
            evt_valid = 1'b1;
            @(negedge clk_sys);
        end
        evt_valid = 1'b0;
        checks += 2;
        if (fifo_level !== 3'd4) begin errors++; $display("FAIL b2b_level got %0d want 4", fifo_level); end
        if (drop_cnt !== 8'd2) begin errors++; $display("FAIL b2b_drop got %0d want 2", drop_cnt); end
        tx_busy = 1'b0;
        wait_idle(1000, "b2b");
`ifdef M68K_ERR_DROP_REPORT_EN
        add_drop(2);
        checks++;
        if (drop_cnt !== 8'd0) begin errors++; $display("FAIL b2b_drop_after got %0d want 0", drop_cnt); end
`else
        checks++;
        if (drop_cnt !== 8'd2) begin errors++; $display("FAIL b2b_drop_after got %0d want 2", drop_cnt); end
`endif
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL b2b_stream byte %0d got %0d bytes want %0d", d, got.size(), exp.size());
        end
    endtask

    task automatic test_saturate();
        int d;
        int drops = 0;
        logic [23:0] a, e;
        do_reset();
        a = 24'($urandom);
        e = 24'($urandom);
        push_evt(a, e);
        add_msg(a, e);
        wait_strobes(1, 100, "sat");
        tx_busy = 1'b1;
        repeat (2) @(negedge clk_sys);
        for (int i = 0; i < 304; i++) begin
            a = 24'($urandom);
            e = 24'($urandom);
            if (i < 4) add_msg(a, e);
            else drops++;
            evt_actual = a;
            evt_expected = e;
            evt_valid = 1'b1;
            @(negedge clk_sys);
        end
        evt_valid = 1'b0;
        if (drops > 255) drops = 255;
        checks += 2;
        if (fifo_level !== 3'd4) begin errors++; $display("FAIL sat_level got %0d want 4", fifo_level); end
        if (drop_cnt !== 8'(drops)) begin errors++; $display("FAIL sat_drop got %0d want %0d", drop_cnt, drops); end
        tx_busy = 1'b0;
        wait_idle(1000, "sat");
`ifdef M68K_ERR_DROP_REPORT_EN
        add_drop(drops);
        checks++;
        if (drop_cnt !== 8'd0) begin errors++; $display("FAIL sat_drop_after got %0d want 0", drop_cnt); end
`else
        checks++;
        if (drop_cnt !== 8'(drops)) begin errors++; $display("FAIL sat_drop_after got %0d want %0d", drop_cnt, drops); end
`endif
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL sat_stream byte %0d got %0d bytes want %0d", d, got.size(), exp.size());
        end
    endtask

    task automatic test_reset_mid();
        int d;
        logic [23:0] a, e;
        do_reset();
        push_evt(24'($urandom), 24'($urandom));
        wait_strobes(1, 100, "rmid");
        tx_busy = 1'b1;
        repeat (2) @(negedge clk_sys);
        evt_valid = 1'b1;
        repeat (6) @(negedge clk_sys);
        evt_valid = 1'b0;
        tx_busy = 1'b0;
        wait_strobes(9, 100, "rmid");
        rst = 1'b1;
        @(negedge clk_sys);
        rst = 1'b0;
        checks += 5;
        if (tx_data !== 8'h00) begin errors++; $display("FAIL rmid_tx_data got %h want 00", tx_data); end
        if (new_tx_data !== 1'b0) begin errors++; $display("FAIL rmid_strobe got %b want 0", new_tx_data); end
        if (drop_cnt !== 8'h00) begin errors++; $display("FAIL rmid_drop got %h want 00", drop_cnt); end
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL rmid_level got %0d want 0", fifo_level); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
        got.delete();
        exp.delete();
        repeat (40) @(negedge clk_sys);
        checks++;
        if (got.size() != 0) begin errors++; $display("FAIL rmid_silence got %0d strobes want 0", got.size()); end
        a = 24'($urandom);
        e = 24'($urandom);
        push_evt(a, e);
        add_msg(a, e);
        wait_idle(200, "rmid");
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL rmid_stream byte %0d got %0d bytes want %0d", d, got.size(), exp.size());
        end
    endtask

    task automatic test_random();
        int d;
        int k = 0;
        int t = 0;
        int when[5];
        do_reset();
        for (int i = 0; i < 5; i++) when[i] = i * 25 + int'($urandom_range(0, 20));
        while (t < 3000) begin
            tx_busy = ($urandom_range(0, 3) == 0);
            if (k < 5 && t == when[k]) begin
                evt_actual = 24'($urandom);
                evt_expected = 24'($urandom);
                evt_valid = 1'b1;
                add_msg(evt_actual, evt_expected);
                k++;
            end else begin
                evt_valid = 1'b0;
            end
            @(negedge clk_sys);
            t++;
            if (k == 5 && !evt_valid && !busy) break;
        end
        evt_valid = 1'b0;
        tx_busy = 1'b0;
        checks++;
        if (busy) begin errors++; $display("FAIL rand_idle busy still 1 want 0"); end
        checks++;
        if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rand_drop got %0d want 0", drop_cnt); end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL rand_stream byte %0d got %0d bytes want %0d", d, got.size(), exp.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
